// File: rtl/avalon_sink_fifo.sv
// Avalon-ST sink FIFO with first-word-fall-through output and rx stats.
// Ports: clk, reset (sync, active-high), valid/data/ready in,
//        out_valid/out_data/out_ready out, rx_count, rx_sum, state.
module avalon_sink_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [15:0]       rx_count,
  output logic [15:0]       rx_sum,
  output logic [1:0]        state
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FULL   = 2'd2
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level;
  logic [LW-1:0]     lvl_nxt;
  logic              push;
  logic              pop;
  state_t            st;

  // ready looks only at the registered level, so a full FIFO
  // refuses a beat even while the head is being popped.
  assign ready     = !reset && (level != FULL_LVL);
  assign out_valid = !reset && (level != '0);
  assign out_data  = mem[rd_ptr];
  assign state     = st;

  assign push    = valid && ready;
  assign pop     = out_valid && out_ready;
  assign lvl_nxt = level + LW'(push) - LW'(pop);

  // Storage is never cleared; level alone says what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rx_count <= '0;
      rx_sum   <= '0;
    end else begin
      level <= lvl_nxt;
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        rx_count <= rx_count + 16'd1;
        rx_sum   <= rx_sum + 16'(data);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Transitions follow the post-edge level so the state
  // always matches occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= ST_EMPTY;
    end else begin
      unique case (st)
        ST_EMPTY: begin
          if (push && !pop) begin
            st <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (lvl_nxt == '0) begin
            st <= ST_EMPTY;
          end else if (lvl_nxt == FULL_LVL) begin
            st <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (pop) begin
            st <= ST_ACTIVE;
          end
        end
        default: st <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_sink_fifo.sv
// Testbench for avalon_sink_fifo: directed scenarios plus random
// traffic, checked against a queue-based reference model.
module tb_avalon_sink_fifo;

  localparam int DW = 8;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid;
  logic [DW-1:0] data;
  logic          ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [15:0]   rx_count;
  logic [15:0]   rx_sum;
  logic [1:0]    state;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] q[$];
  logic [15:0]   m_cnt = '0;
  logic [15:0]   m_sum = '0;

  always #5 clk = ~clk;

  avalon_sink_fifo #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid     (valid),
    .data      (data),
    .ready     (ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .rx_count  (rx_count),
    .rx_sum    (rx_sum),
    .state     (state)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // Called at a negedge: drive inputs, predict the next edge,
  // then compare at the following negedge.
  task automatic step(input logic v,
                      input logic [DW-1:0] d,
                      input logic ordy,
                      input logic rst,
                      output logic acc);
    logic do_pop;
    int   sz;
    reset     = rst;
    valid     = v;
    data      = d;
    out_ready = ordy;
    acc       = 1'b0;
    if (rst) begin
      q.delete();
      m_cnt = '0;
      m_sum = '0;
    end else begin
      do_pop = (q.size() != 0) && ordy;
      acc    = v && (q.size() != DP);
      if (do_pop) void'(q.pop_front());
      if (acc) begin
        q.push_back(d);
        m_cnt = m_cnt + 16'd1;
        m_sum = m_sum + 16'(d);
      end
    end
    @(negedge clk);
    sz = q.size();
    chk("ready", 32'(ready), 32'(!rst && sz != DP));
    chk("out_valid", 32'(out_valid), 32'(!rst && sz != 0));
    if (!rst && sz != 0) chk("out_data", 32'(out_data), 32'(q[0]));
    chk("rx_count", 32'(rx_count), 32'(m_cnt));
    chk("rx_sum", 32'(rx_sum), 32'(m_sum));
    chk("state", 32'(state),
        (sz == 0) ? 32'd0 : (sz == DP) ? 32'd2 : 32'd1);
  endtask

  task automatic idle_n(input int n, input logic ordy);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, '0, ordy, 1'b0, a);
  endtask

  task automatic do_reset(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b1, 8'hEE, 1'b0, 1'b1, a);
  endtask

  initial begin
    logic a;
    int   k;
    int   guard;

    reset = 1'b1; valid = 1'b0; data = '0; out_ready = 1'b0;

    // reset held three cycles, then ready right after release
    do_reset(3);
    chk("rst_rx_count", 32'(rx_count), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    idle_n(1, 1'b0);
    chk("post_rst_ready", 32'(ready), 32'd1);

    // back-to-back stream with consumer always ready
    for (int i = 4; i <= 6; i++) step(1'b1, DW'(i), 1'b1, 1'b0, a);
    idle_n(2, 1'b1);
    chk("stream_count", 32'(rx_count), 32'd3);
    chk("stream_sum", 32'(rx_sum), 32'd15);
    chk("stream_state", 32'(state), 32'd0);

    // backpressure: fill with 1..4, hold 5
    do_reset(1);
    k = 1;
    guard = 0;
    while (k <= 4 && guard < 20) begin
      step(1'b1, DW'(k), 1'b0, 1'b0, a);
      if (a) k++;
      guard++;
    end
    chk("bp_fill_guard", 32'(k), 32'd5);
    step(1'b1, 8'd5, 1'b0, 1'b0, a);
    chk("bp_full_refuse", 32'(a), 32'd0);
    chk("bp_full_state", 32'(state), 32'd2);
    chk("bp_full_ready", 32'(ready), 32'd0);
    // pop while full: no push this edge, level drops to 3
    step(1'b1, 8'd5, 1'b1, 1'b0, a);
    chk("fp_no_push", 32'(a), 32'd0);
    chk("fp_head", 32'(out_data), 32'd2);
    chk("fp_state", 32'(state), 32'd1);
    step(1'b1, 8'd5, 1'b0, 1'b0, a);
    chk("fp_push_next", 32'(a), 32'd1);
    chk("bp_sum", 32'(rx_sum), 32'd15);
    idle_n(6, 1'b1);

    // pointer wrap with out_ready toggling every cycle
    do_reset(1);
    k = 0;
    guard = 0;
    while (k < 10 && guard < 60) begin
      step(1'b1, DW'(8'h10 + k), 1'(guard & 1), 1'b0, a);
      if (a) k++;
      guard++;
    end
    chk("wrap_guard", 32'(k), 32'd10);
    idle_n(8, 1'b1);
    chk("wrap_count", 32'(rx_count), 32'd10);
    chk("wrap_sum", 32'(rx_sum), 32'h00CD);
    chk("wrap_state", 32'(state), 32'd0);

    // reset in the middle with a beat presented
    step(1'b1, 8'h21, 1'b0, 1'b0, a);
    step(1'b1, 8'h22, 1'b0, 1'b0, a);
    chk("mid_state", 32'(state), 32'd1);
    step(1'b1, 8'h99, 1'b0, 1'b1, a);
    idle_n(1, 1'b1);
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_count", 32'(rx_count), 32'd0);
    chk("mid_sum", 32'(rx_sum), 32'd0);

    // random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 2) != 0),
           DW'($urandom),
           1'($urandom_range(0, 2) == 0 ? 0 : 1),
           1'($urandom_range(0, 59) == 0),
           a);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
